// File: rtl/npc_pkg.sv
// Shared NPC core definitions: fetch state encoding, reset PC, NOP encoding
// and the default address width.
package npc_pkg;

  localparam int          NPC_ADDR_W   = 32;
  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NPC_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // A fetch target is misaligned when either of its two low bits is set.
  function automatic logic pc_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register for the fetch stage. A redirect takes priority
// over the sequential +4 step; the increment wraps modulo 2^ADDR_W.
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter int                ADDR_W   = NPC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NPC_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              incr_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_next;

  // Select the next PC: redirect target, sequential successor, or hold.
  always_comb begin
    pc_next = pc;
    if (redirect_en) begin
      pc_next = redirect_pc;
    end else if (incr_en) begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  // PC state register with synchronous reset to the boot address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and hands each fetched word to decode.
// Optional feature macro IFU_MISALIGN_CHECK_EN: a redirect to a target whose
// two low bits are non-zero raises a sticky misalign_fault and parks the
// stage in FAULT until reset. Without the macro the target is used as given.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int                ADDR_W   = NPC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NPC_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign_fault
);

  fetch_state_e      state;
  logic              drop;      // outstanding response belongs to a stale PC
  logic [ADDR_W-1:0] pc;
  logic              req_fire;
  logic              redir_bad;
  logic              pc_redirect_en;
  logic              pc_incr_en;

  // Requests go out only from REQ, never while halted or during reset.
  assign imem_req_valid = (state == ST_REQ) && !halt && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_bad = redirect_valid && (state != ST_FAULT) &&
                     pc_misaligned(redirect_pc[1:0]);

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_fault <= 1'b0;
    end else if (redir_bad) begin
      misalign_fault <= 1'b1;
    end
  end
`else
  assign redir_bad      = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  // Redirects are ignored once faulted; the sequential step happens only when
  // a live response is accepted and no redirect overrides it.
  assign pc_redirect_en = redirect_valid && (state != ST_FAULT);
  assign pc_incr_en     = (state == ST_WAIT) && imem_resp_valid && !drop &&
                          !redirect_valid;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (pc_redirect_en),
    .redirect_pc (redirect_pc),
    .incr_en     (pc_incr_en),
    .pc          (pc)
  );

  // Fetch control FSM with registered decode-facing outputs; a redirect wins
  // over every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_REQ;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NPC_NOP;
      inst_pc    <= RESET_PC;
    end else begin
      case (state)
        ST_REQ: begin
          if (redirect_valid) begin
            if (redir_bad) begin
              state <= ST_FAULT;
            end else if (req_fire) begin
              drop  <= 1'b1;
              state <= ST_WAIT;
            end
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            if (redir_bad) begin
              drop  <= 1'b0;
              state <= ST_FAULT;
            end else if (imem_resp_valid) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              inst       <= imem_resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            state      <= redir_bad ? ST_FAULT : ST_REQ;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= ST_REQ;
          end
        end
        default: begin
          inst_valid <= 1'b0;
          state      <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a flag-based behavioural model of the fetch stage plus
// a latency-programmable memory, driven by directed scenarios and random
// stimulus; every cycle the DUT outputs are compared with the model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_fault;

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .misalign_fault  (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetch stage described by what it is doing, not by state.
  logic [31:0] m_pc;
  bit          m_busy;   // a request is outstanding at memory
  bit          m_stale;  // the outstanding response must be thrown away
  bit          m_held;   // an instruction is being offered to decode
  logic [31:0] m_hinst;
  logic [31:0] m_hpc;
  bit          m_fault;

  // Memory model.
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_pc    = 32'h8000_0000;
    m_busy  = 0;
    m_stale = 0;
    m_held  = 0;
    m_hinst = 32'h0000_0013;
    m_hpc   = 32'h8000_0000;
    m_fault = 0;
  endtask

  // One clock cycle: memory drives its response, outputs are compared with the
  // model, the model advances, then the clock edge passes.
  task automatic cycle();
    logic [31:0] pc_old;
    bit          req_exp;
    bit          fire;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memword(mem_addr);
        mem_pend        = 0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
    req_exp = !rst && !m_busy && !m_held && !m_fault && !halt;
    check("req_valid", imem_req_valid, req_exp);
    if (req_exp) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", inst_valid, m_held);
    check("inst", inst, m_hinst);
    check("inst_pc", inst_pc, m_hpc);
    check("misalign_fault", misalign_fault, m_fault);
    fire   = req_exp && imem_req_ready;
    pc_old = m_pc;
    if (rst) begin
      model_reset();
    end else if (!m_fault) begin
      if (redirect_valid) begin
        if (m_held) begin
          m_held = 0;
        end else if (m_busy) begin
          if (imem_resp_valid) begin
            m_busy  = 0;
            m_stale = 0;
          end else begin
            m_stale = 1;
          end
        end else if (fire) begin
          m_busy  = 1;
          m_stale = 1;
        end
        m_pc = redirect_pc;
`ifdef IFU_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_fault = 1;
          m_held  = 0;
        end
`endif
      end else if (m_held) begin
        if (inst_ready) m_held = 0;
      end else if (m_busy) begin
        if (imem_resp_valid) begin
          m_busy = 0;
          if (m_stale) begin
            m_stale = 0;
          end else begin
            m_held  = 1;
            m_hinst = imem_resp_data;
            m_hpc   = m_pc;
            m_pc    = m_pc + 32'd4;
          end
        end
      end else if (fire) begin
        m_busy = 1;
      end
    end
    if (fire) begin
      mem_pend = 1;
      mem_addr = pc_old;
      mem_cnt  = lat;
    end
    if (rst) mem_pend = 0;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    inst_ready     = 1'b1;
    lat            = 0;
    mem_pend       = 0;
    mem_cnt        = 0;
    mem_addr       = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();  // reset-state comparison

    // Zero-wait fetch of the boot word.
    #1;
    check("boot_req_valid", imem_req_valid, 1'b1);
    check("boot_req_addr", imem_req_addr, 32'h8000_0000);
    cycle();
    cycle();
    check("boot_inst_valid", inst_valid, 1'b1);
    check("boot_inst", inst, 32'h0000_0513);
    check("boot_inst_pc", inst_pc, 32'h8000_0000);
    cycle();
    check("seq_req_addr", imem_req_addr, 32'h8000_0004);

    // Decode backpressure for five cycles.
    inst_ready = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_inst", inst, memword(32'h8000_0004));
      check("bp_inst_pc", inst_pc, 32'h8000_0004);
    end
    inst_ready = 1'b1;
    cycle();
    check("bp_released", inst_valid, 1'b0);
    check("bp_next_addr", imem_req_addr, 32'h8000_0008);

    // Redirect in WAIT, stale response two cycles later.
    lat = 2;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    cycle();
    lat = 0;
    cycle();
    cycle();
    check("wait_redir_no_inst", inst_valid, 1'b0);
    check("wait_redir_req", imem_req_valid, 1'b1);
    check("wait_redir_addr", imem_req_addr, 32'h8000_0100);

    // Redirect in HOLD with decode ready in the same cycle.
    cycle();
    cycle();
    check("hold_inst_pc", inst_pc, 32'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    inst_ready     = 1'b1;
    cycle();
    check("hold_redir_inst_valid", inst_valid, 1'b0);
    check("hold_redir_addr", imem_req_addr, 32'h8000_0200);

    // Halt while a request is outstanding.
    lat = 1;
    cycle();
    halt = 1'b1;
    cycle();
    cycle();
    check("halt_delivered", inst_valid, 1'b1);
    check("halt_inst_pc", inst_pc, 32'h8000_0200);
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("halt_no_req", imem_req_valid, 1'b0);
      cycle();
    end
    halt = 1'b0;
    #1;
    check("unhalt_req", imem_req_valid, 1'b1);
    check("unhalt_addr", imem_req_addr, 32'h8000_0204);

    // Reset while WAIT.
    lat = 3;
    cycle();
    rst = 1'b1;
    cycle();
    lat = 0;
    check("rst_wait_inst_valid", inst_valid, 1'b0);
    check("rst_wait_addr", imem_req_addr, 32'h8000_0000);

    // Redirect in REQ without and with a same-cycle handshake; PC wrap.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    imem_req_ready = 1'b1;
    check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    cycle();
    cycle();
    check("req_redir_dropped", inst_valid, 1'b0);
    check("req_redir_addr", imem_req_addr, 32'h8000_0300);

    // Misaligned redirect target.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    cycle();
    imem_req_ready = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
    check("misalign_set", misalign_fault, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("fault_no_req", imem_req_valid, 1'b0);
      cycle();
    end
    rst = 1'b1;
    cycle();
    check("fault_cleared", misalign_fault, 1'b0);
`else
    check("misalign_unused", misalign_fault, 1'b0);
    check("misalign_addr", imem_req_addr, 32'h8000_0102);
`endif

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      inst_ready     = ($urandom % 3) != 0;
      halt           = ($urandom % 8) == 0;
      lat            = $urandom % 4;
      rst            = ($urandom % 250) == 0;
      redirect_valid = ($urandom % 12) == 0;
`ifdef IFU_MISALIGN_CHECK_EN
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 40) == 0) redirect_pc = redirect_pc | 32'h1;
`else
      redirect_pc    = $urandom;
      if (($urandom % 2) == 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of the NPC core; sits directly upstream of the decode stage and feeds it one 32-bit instruction at a time.
- Owns the PC register and issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface.
- Presents the fetched instruction to decode with a valid/ready handshake.
- Accepts PC redirects from the branch/jump resolution logic and a halt from the ebreak trap path.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
ADDR_W, 32, width of PC and memory address

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  synchronous active-high reset
halt  in  1  level; when 1, no new memory request is issued
redirect_valid  in  1  one-cycle pulse: replace the PC with redirect_pc
redirect_pc  in  ADDR_W  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  ADDR_W  fetch address, equal to the current PC
imem_resp_valid  in  1  response data valid, one cycle
imem_resp_data  in  32  fetched instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes the instruction this cycle
inst  out  32  instruction to decode
inst_pc  out  ADDR_W  PC of inst
misalign_fault  out  1  sticky redirect-misalignment flag (see Optional Feature)

Behaviour:
- States: REQ, WAIT, HOLD, plus FAULT (only with the optional feature). Internal drop flag.
- Reset (rst=1 at posedge), same for reset mid-operation:
  - pc=RESET_PC, state=REQ, drop=0.
  - inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, misalign_fault=0.
  - imem_req_valid=0 during the reset cycle.
  - Instruction memory is reset by the same rst. A response arriving in REQ or HOLD is ignored.
- REQ:
  - imem_req_valid = ~halt, imem_req_addr = pc.
  - If imem_req_valid and imem_req_ready, go to WAIT.
- WAIT:
  - imem_req_valid=0. Wait any number of cycles for imem_resp_valid.
  - On imem_resp_valid with drop=1: clear drop, discard the data, go to REQ.
  - On imem_resp_valid with drop=0: inst<=imem_resp_data, inst_pc<=pc, pc<=pc+4, inst_valid<=1, go to HOLD.
- HOLD:
  - inst_valid=1. inst and inst_pc stay stable until inst_valid & inst_ready, then inst_valid<=0 and go to REQ.
- Latency:
  - inst_valid rises the cycle after imem_resp_valid.
  - Next request is issued the cycle after the decode handshake.
  - Minimum 3 cycles per instruction with a zero-wait memory.
- Redirect has priority over every other event in the same cycle:
  - REQ: pc<=redirect_pc, stay in REQ. If the request handshake also completes that cycle, drop<=1 and go to WAIT.
  - WAIT: pc<=redirect_pc. If imem_resp_valid is also high, discard the data and go to REQ with drop=0. Otherwise drop<=1.
  - HOLD: pc<=redirect_pc, inst_valid<=0, go to REQ. The held instruction is discarded even if inst_ready=1 that cycle.
- PC arithmetic: pc+4 wraps modulo 2^ADDR_W. No overflow detection.
- halt affects only new requests. An outstanding request completes, and a held instruction is still delivered.
- At most one outstanding memory request at any time.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign_fault=1 (sticky until rst) and moves to FAULT.
  - In FAULT: imem_req_valid=0, inst_valid=0, responses and redirects are ignored.
  - An outstanding response arriving in FAULT is discarded.
- Undefined:
  - misalign_fault is tied to 0 and the FAULT state does not exist.
  - redirect_pc is used unmodified, including its low bits.

Decomposition:
- Shared package npc_pkg:
  - fetch state enum (REQ/WAIT/HOLD/FAULT)
  - RESET_PC default constant
  - NOP encoding 32'h0000_0013
  - ADDR_W default
- One natural sub-module, ifu_pc_reg: PC register with reset, increment and redirect-select muxing. The FSM stays in ifu_fetch.

Test Plan:
- Reset, then zero-wait memory returning 32'h00000513 at 0x80000000 -> imem_req_addr=0x80000000; inst_valid=1 one cycle after resp with inst=32'h00000513, inst_pc=0x80000000; next request at 0x80000004.
- Decode backpressure (inst_ready=0 for 5 cycles) -> inst and inst_pc stable, no new request, single consume after release.
- Redirect to 0x80000100 while in WAIT, response arriving 2 cycles later -> response dropped, next request at 0x80000100, inst_valid never set for the old word.
- Redirect in HOLD with inst_ready=1 in the same cycle -> instruction not consumed, next request at the redirect target.
- halt=1 during WAIT -> pending instruction delivered, no further imem_req_valid until halt=0; rst pulse mid-WAIT -> pc=0x80000000, inst_valid=0.
- With IFU_MISALIGN_CHECK_EN: redirect_pc=0x80000102 -> misalign_fault=1, no further requests until rst.
